// File: rtl/round_increment_pipe_pkg.sv
// Shared rounding definitions: IEEE rounding-mode encodings and the bit
// positions of lsb/guard/round inside an aligned significand.
package round_increment_pipe_pkg;

    localparam logic [1:0] RND_NEAR_EVEN = 2'b00;
    localparam logic [1:0] RND_MIN_MAG   = 2'b01;
    localparam logic [1:0] RND_MIN       = 2'b10;
    localparam logic [1:0] RND_MAX       = 2'b11;

    localparam int LSB_IDX   = 2;
    localparam int GUARD_IDX = 1;
    localparam int ROUND_IDX = 0;

endpackage

// File: rtl/round_increment_pipe_round_decide.sv
// Combinational rounding decision: whether to add one ulp to the kept bits,
// and whether any discarded bit was set.
module round_decide
    import round_increment_pipe_pkg::*;
(
    input  logic       lsb,
    input  logic       g,
    input  logic       rs,
    input  logic       sign,
    input  logic [1:0] mode,
    output logic       inc,
    output logic       inexact
);

    always_comb begin
        inexact = g | rs;
        inc     = 1'b0;
        case (mode)
            RND_NEAR_EVEN: inc = g & (rs | lsb);
            RND_MIN_MAG:   inc = 1'b0;
            RND_MIN:       inc = sign & (g | rs);
            RND_MAX:       inc = ~sign & (g | rs);
        endcase
    end

endmodule

// File: rtl/round_increment_pipe.sv
// Two-stage rounding pipeline: stage 1 registers the rounding decision,
// stage 2 registers the incremented significand. Valid/ready on both ends.
module round_increment_pipe
    import round_increment_pipe_pkg::*;
#(
    parameter int SIG_WIDTH = 24,
    parameter int TAG_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SIG_WIDTH+1:0]   in_sig,
    input  logic                   in_sticky,
    input  logic                   in_sign,
    input  logic [1:0]             in_rnd_mode,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SIG_WIDTH-1:0]   out_sig,
    output logic                   out_carry,
    output logic                   out_inexact,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    logic                 dec_inc;
    logic                 dec_inexact;
    logic                 s1_adv;
    logic                 s2_adv;

    logic                 s1_valid;
    logic [SIG_WIDTH-1:0] s1_kept;
    logic                 s1_inc;
    logic                 s1_inexact;
    logic [TAG_WIDTH-1:0] s1_tag;

    logic                 s2_valid;
    logic [SIG_WIDTH-1:0] s2_sig;
    logic                 s2_carry;
    logic                 s2_inexact;
    logic [TAG_WIDTH-1:0] s2_tag;

    logic [SIG_WIDTH:0]   sum;

    round_decide u_round_decide (
        .lsb     (in_sig[LSB_IDX]),
        .g       (in_sig[GUARD_IDX]),
        .rs      (in_sig[ROUND_IDX] | in_sticky),
        .sign    (in_sign),
        .mode    (in_rnd_mode),
        .inc     (dec_inc),
        .inexact (dec_inexact)
    );

    // Ready ripples back combinationally: a stage may load whenever it is
    // empty or its contents are leaving this cycle.
    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;

    assign sum = {1'b0, s1_kept} + {{SIG_WIDTH{1'b0}}, s1_inc};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_kept    <= '0;
            s1_inc     <= 1'b0;
            s1_inexact <= 1'b0;
            s1_tag     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_kept    <= in_sig[SIG_WIDTH+1:LSB_IDX];
                s1_inc     <= dec_inc;
                s1_inexact <= dec_inexact;
                s1_tag     <= in_tag;
            end
        end
    end

    // Data only loads with a valid beat, so a stalled output never changes
    // and a bubble passing through leaves the last beat's data untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid   <= 1'b0;
            s2_sig     <= '0;
            s2_carry   <= 1'b0;
            s2_inexact <= 1'b0;
            s2_tag     <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sig     <= sum[SIG_WIDTH-1:0];
                s2_carry   <= sum[SIG_WIDTH];
                s2_inexact <= s1_inexact;
                s2_tag     <= s1_tag;
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_sig     = s2_sig;
    assign out_carry   = s2_carry;
    assign out_inexact = s2_inexact;
    assign out_tag     = s2_tag;

endmodule

// File: tb/tb_round_increment_pipe.sv
// Scoreboarded bench for round_increment_pipe at SIG_WIDTH=4: fixed rounding
// cases, backpressure, full-rate streaming, random stalls and mid-flight reset.
module tb_round_increment_pipe;

    typedef struct packed {
        logic [3:0] sig;
        logic       carry;
        logic       inexact;
        logic [9:0] tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_sig = '0;
    logic       in_sticky = 1'b0;
    logic       in_sign = 1'b0;
    logic [1:0] in_rnd_mode = 2'b00;
    logic [9:0] in_tag = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_sig;
    logic       out_carry;
    logic       out_inexact;
    logic [9:0] out_tag;

    int   checks = 0;
    int   errors = 0;
    int   accepted = 0;
    exp_t sb[$];
    bit   held_valid = 0;
    exp_t held;

    round_increment_pipe #(.SIG_WIDTH(4), .TAG_WIDTH(10)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sig      (in_sig),
        .in_sticky   (in_sticky),
        .in_sign     (in_sign),
        .in_rnd_mode (in_rnd_mode),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sig     (out_sig),
        .out_carry   (out_carry),
        .out_inexact (out_inexact),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    // Reference rounding written in terms of the discarded remainder.
    function automatic exp_t model(input logic [5:0] s, input logic st, input logic sg,
                                   input logic [1:0] m, input logic [9:0] t);
        exp_t       r;
        logic [1:0] rem;
        logic       up;
        logic [4:0] total;
        rem = {s[1], s[0] | st};
        case (m)
            2'b00:   up = (rem == 2'b11) || (rem == 2'b10 && s[2]);
            2'b01:   up = 1'b0;
            2'b10:   up = sg && (rem != 2'b00);
            default: up = !sg && (rem != 2'b00);
        endcase
        total     = {1'b0, s[5:2]} + {4'b0000, up};
        r.sig     = total[3:0];
        r.carry   = total[4];
        r.inexact = (rem != 2'b00);
        r.tag     = t;
        return r;
    endfunction

    // Output monitor: pops the scoreboard on each transfer and checks that a
    // stalled output beat holds steady until it is taken.
    always @(negedge clk) begin
        if (!reset_n) begin
            held_valid = 0;
        end else begin
            if (held_valid) begin
                checks++;
                if (out_valid !== 1'b1 || {out_sig, out_carry, out_inexact, out_tag} !== held) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got v=%b %h/%b/%b/%0d need v=1 %h/%b/%b/%0d",
                             out_valid, out_sig, out_carry, out_inexact, out_tag,
                             held.sig, held.carry, held.inexact, held.tag);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got tag %0d with empty scoreboard", out_tag);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({out_sig, out_carry, out_inexact, out_tag} !== e) begin
                        errors++;
                        $display("[TB] FAIL beat_data: got sig=%b c=%b x=%b tag=%0d need sig=%b c=%b x=%b tag=%0d",
                                 out_sig, out_carry, out_inexact, out_tag,
                                 e.sig, e.carry, e.inexact, e.tag);
                    end
                end
            end
            held_valid = (out_valid === 1'b1 && out_ready === 1'b0);
            held       = {out_sig, out_carry, out_inexact, out_tag};
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Presents one beat (called just after a rising edge), waits for the
    // handshake and records its expected result.
    task automatic send_beat(input logic [5:0] s, input logic st, input logic sg,
                             input logic [1:0] m, input logic [9:0] t, input exp_t e);
        int  n = 0;
        bit  ok = 1;
        in_valid    = 1'b1;
        in_sig      = s;
        in_sticky   = st;
        in_sign     = sg;
        in_rnd_mode = m;
        in_tag      = t;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
            if (n > 100) begin
                ok = 0;
                break;
            end
        end
        if (ok) begin
            sb.push_back(e);
            accepted++;
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=%b for tag %0d need 1", in_ready, t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sig   = 6'h2a;
    endtask

    task automatic drain(output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && out_valid === 1'b0) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({out_valid, out_sig, out_carry, out_inexact, out_tag} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%b sig=%b c=%b x=%b tag=%0d need all zero",
                     out_valid, out_sig, out_carry, out_inexact, out_tag);
        end
        #6 reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b need 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rne_ties;
        bit ok;
        out_ready = 1'b1;
        send_beat(6'b010110, 1'b0, 1'b0, 2'b00, 10'd5, exp_t'{4'b0110, 1'b0, 1'b1, 10'd5});
        send_beat(6'b010010, 1'b0, 1'b0, 2'b00, 10'd6, exp_t'{4'b0100, 1'b0, 1'b1, 10'd6});
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL rne_drain: got %0d beats left need 0", sb.size());
        end
    endtask

    task automatic test_overflow_latency;
        bit ok;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_sig      = 6'b111100;
        in_sticky   = 1'b1;
        in_sign     = 1'b0;
        in_rnd_mode = 2'b11;
        in_tag      = 10'd7;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_accept: got in_ready=%b need 1", in_ready);
        end
        sb.push_back(exp_t'{4'b0000, 1'b1, 1'b1, 10'd7});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_latency_early: got out_valid=%b need 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_sig !== 4'b0000 || out_carry !== 1'b1 || out_inexact !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_result: got v=%b sig=%b c=%b x=%b need v=1 sig=0000 c=1 x=1",
                     out_valid, out_sig, out_carry, out_inexact);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL ovf_drain: got %0d beats left need 0", sb.size());
        end
    endtask

    task automatic test_modes;
        bit ok;
        out_ready = 1'b1;
        send_beat(6'b111100, 1'b1, 1'b0, 2'b10, 10'd20, exp_t'{4'b1111, 1'b0, 1'b1, 10'd20});
        send_beat(6'b111100, 1'b1, 1'b1, 2'b10, 10'd21, exp_t'{4'b0000, 1'b1, 1'b1, 10'd21});
        send_beat(6'b101000, 1'b0, 1'b0, 2'b01, 10'd22, exp_t'{4'b1010, 1'b0, 1'b0, 10'd22});
        for (int i = 0; i < 40; i++) begin
            logic [5:0] s;
            logic       st;
            logic       sg;
            logic [1:0] m;
            s  = 6'($urandom);
            st = 1'($urandom);
            sg = 1'($urandom);
            m  = 2'($urandom);
            send_beat(s, st, sg, m, 10'(100 + i), model(s, st, sg, m, 10'(100 + i)));
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL modes_drain: got %0d beats left need 0", sb.size());
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        accepted  = 0;
        out_ready = 1'b0;
        fork
            begin
                for (int t = 1; t <= 4; t++)
                    send_beat(6'(t * 9), 1'b0, 1'b0, 2'b00, 10'(t),
                              model(6'(t * 9), 1'b0, 1'b0, 2'b00, 10'(t)));
            end
            begin
                repeat (5) @(negedge clk);
                checks++;
                if (accepted !== 2 || in_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL bp_in_ready: got accepted=%0d in_ready=%b need 2 and 0",
                             accepted, in_ready);
                end
                checks++;
                if (out_valid !== 1'b1 || out_tag !== 10'd1) begin
                    errors++;
                    $display("[TB] FAIL bp_hold: got v=%b tag=%0d need v=1 tag=1", out_valid, out_tag);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain(ok);
        checks++;
        if (!ok || accepted !== 4) begin
            errors++;
            $display("[TB] FAIL bp_drain: got %0d left, %0d accepted need 0 and 4", sb.size(), accepted);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_beat(6'(i * 7 + 3), 1'(i), 1'b0, 2'b00, 10'(11 + i),
                              model(6'(i * 7 + 3), 1'(i), 1'b0, 2'b00, 10'(11 + i)));
            end
            begin
                int first = 0;
                int run = 0;
                for (int n = 1; n <= 20; n++) begin
                    @(negedge clk);
                    if (out_valid === 1'b1) begin
                        first = n;
                        break;
                    end
                end
                checks++;
                if (first !== 3) begin
                    errors++;
                    $display("[TB] FAIL b2b_latency: got first valid at negedge %0d need 3", first);
                end
                if (first != 0) begin
                    run = 1;
                    for (int n = 0; n < 20; n++) begin
                        @(negedge clk);
                        if (out_valid !== 1'b1) break;
                        run++;
                    end
                end
                checks++;
                if (run !== 8) begin
                    errors++;
                    $display("[TB] FAIL b2b_run: got %0d consecutive valid cycles need 8", run);
                end
            end
        join
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL b2b_drain: got %0d beats left need 0", sb.size());
        end
    endtask

    task automatic test_random_stall;
        bit ok;
        bit done = 0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    logic [5:0] s;
                    logic       st;
                    logic       sg;
                    logic [1:0] m;
                    s  = 6'($urandom);
                    st = 1'($urandom);
                    sg = 1'($urandom);
                    m  = 2'($urandom);
                    send_beat(s, st, sg, m, 10'(200 + i), model(s, st, sg, m, 10'(200 + i)));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL stall_drain: got %0d beats left need 0", sb.size());
        end
    endtask

    task automatic test_reset_midflight;
        int stray = 0;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_sig      = 6'b011000;
        in_sticky   = 1'b0;
        in_sign     = 1'b0;
        in_rnd_mode = 2'b00;
        in_tag      = 10'd300;
        @(posedge clk);
        #1;
        in_tag = 10'd301;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_async: got out_valid=%b need 0", out_valid);
        end
        sb.delete();
        @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_in_ready: got %b need 1", in_ready);
        end
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("[TB] FAIL midreset_stale: got %0d stale valid cycles need 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_rne_ties();
        test_overflow_latency();
        test_modes();
        test_backpressure();
        test_back_to_back();
        test_random_stall();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
